// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with optional two-entry skid buffer, flush and
// saturating stall/flush statistics. Idle output carries a NOP payload.
`timescale 1ns/1ps
module pipe_stage_reg #(
    parameter int                DATA_W      = 96,
    parameter logic [DATA_W-1:0] NOP_PAYLOAD = DATA_W'({32'h00000000, 32'h00000004, 32'h00000013}),
    parameter bit                SKID_EN     = 1'b1,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [DATA_W-1:0] dn_data_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    // State code equals the number of held beats so occupancy is the state itself.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic [1:0]        w_state_next;
    logic [DATA_W-1:0] w_main_next;
    logic [DATA_W-1:0] w_skid_next;
    logic              w_dn_valid;
    logic              w_up_xfer;
    logic              w_dn_xfer;
    logic              w_stall;

    assign w_dn_valid = (r_state != ST_EMPTY);
    assign w_up_xfer  = up_valid_i & up_ready_o;
    assign w_dn_xfer  = w_dn_valid & dn_ready_i;
    assign w_stall    = w_dn_valid & ~dn_ready_i;

    always_comb begin
        w_state_next = r_state;
        w_main_next  = r_main;
        w_skid_next  = r_skid;
        if (flush_i) begin
            w_state_next = ST_EMPTY;
            w_main_next  = NOP_PAYLOAD;
            w_skid_next  = NOP_PAYLOAD;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_up_xfer) begin
                        w_state_next = ST_ONE;
                        w_main_next  = up_data_i;
                    end
                end
                ST_ONE: begin
                    if (w_up_xfer && w_dn_xfer) begin
                        w_main_next = up_data_i;
                    end else if (w_dn_xfer) begin
                        w_state_next = ST_EMPTY;
                        w_main_next  = NOP_PAYLOAD;
                    end else if (w_up_xfer && SKID_EN) begin
                        w_state_next = ST_TWO;
                        w_skid_next  = up_data_i;
                    end
                end
                ST_TWO: begin
                    if (w_dn_xfer) begin
                        w_state_next = ST_ONE;
                        w_main_next  = r_skid;
                        w_skid_next  = NOP_PAYLOAD;
                    end
                end
                default: begin
                    w_state_next = ST_EMPTY;
                    w_main_next  = NOP_PAYLOAD;
                    w_skid_next  = NOP_PAYLOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_main      <= NOP_PAYLOAD;
            r_skid      <= NOP_PAYLOAD;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_main  <= w_main_next;
            r_skid  <= w_skid_next;
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (flush_i && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    // The skid variant registers ready so it never depends on dn_ready_i combinationally.
    generate
        if (SKID_EN) begin : g_skid_ready
            logic r_up_ready;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_up_ready <= 1'b1;
                end else begin
                    r_up_ready <= (w_state_next != ST_TWO);
                end
            end
            assign up_ready_o = r_up_ready;
        end else begin : g_comb_ready
            assign up_ready_o = dn_ready_i | ~w_dn_valid;
        end
    endgenerate

    assign dn_valid_o  = w_dn_valid;
    assign dn_data_o   = r_main;
    assign occupancy_o = r_state;
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Two stage configurations (skid/16-bit counters, no-skid/4-bit counters) share
// one stimulus stream; each is scored against a queue-based model of held beats.
`timescale 1ns/1ps
module tb_pipe_stage_reg;

    localparam logic [95:0] NOP = {32'h00000000, 32'h00000004, 32'h00000013};

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        flush    = 1'b0;
    logic        up_valid = 1'b0;
    logic        dn_ready = 1'b0;
    logic [95:0] up_data  = '0;

    logic        act_valid [2];
    logic        act_ready [2];
    logic [95:0] act_data  [2];
    logic [1:0]  act_occ   [2];
    logic [15:0] act_stall [2];
    logic [15:0] act_flush [2];
    logic [3:0]  stall1;
    logic [3:0]  flush1;

    assign act_stall[1] = {12'd0, stall1};
    assign act_flush[1] = {12'd0, flush1};

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(96), .NOP_PAYLOAD(NOP), .SKID_EN(1'b1), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .up_valid_i(up_valid), .up_ready_o(act_ready[0]), .up_data_i(up_data),
        .dn_valid_o(act_valid[0]), .dn_ready_i(dn_ready), .dn_data_o(act_data[0]),
        .occupancy_o(act_occ[0]), .stall_cnt_o(act_stall[0]), .flush_cnt_o(act_flush[0])
    );

    pipe_stage_reg #(.DATA_W(96), .NOP_PAYLOAD(NOP), .SKID_EN(1'b0), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .up_valid_i(up_valid), .up_ready_o(act_ready[1]), .up_data_i(up_data),
        .dn_valid_o(act_valid[1]), .dn_ready_i(dn_ready), .dn_data_o(act_data[1]),
        .occupancy_o(act_occ[1]), .stall_cnt_o(stall1), .flush_cnt_o(flush1)
    );

    // Model: q_exp[k][0 .. held[k]-1] are the beats held after the last edge;
    // entries beyond held[k] were accepted by the driver for the coming edge.
    logic [95:0] q_exp [2][$];
    int          held      [2] = '{0, 0};
    int          exp_stall [2] = '{0, 0};
    int          exp_flush [2] = '{0, 0};
    int          cnt_max   [2] = '{65535, 15};
    bit          skid_cfg  [2] = '{1'b1, 1'b0};
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input int k, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got=%h want=%h", name, k, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [95:0] e_data;
        bit          e_ready;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                q_exp[k].delete();
                held[k]      = 0;
                exp_stall[k] = 0;
                exp_flush[k] = 0;
            end
            e_data  = (held[k] > 0) ? q_exp[k][0] : NOP;
            e_ready = skid_cfg[k] ? (held[k] < 2) : ((held[k] == 0) || dn_ready);
            chk("dn_valid", k, 96'(act_valid[k]), 96'(held[k] > 0));
            chk("dn_data", k, act_data[k], e_data);
            chk("up_ready", k, 96'(act_ready[k]), 96'(e_ready));
            chk("occupancy", k, 96'(act_occ[k]), 96'(held[k]));
            chk("stall_cnt", k, 96'(act_stall[k]), 96'(exp_stall[k]));
            chk("flush_cnt", k, 96'(act_flush[k]), 96'(exp_flush[k]));
            if (rst_n) begin
                if (held[k] > 0 && !dn_ready && exp_stall[k] < cnt_max[k]) exp_stall[k]++;
                if (flush && exp_flush[k] < cnt_max[k]) exp_flush[k]++;
                if (held[k] > 0 && dn_ready) begin
                    $display("dut%0d out pc=%h insn=%h%s", k, q_exp[k][0][95:64], q_exp[k][0][31:0],
                             flush ? " (flush cycle)" : "");
                    void'(q_exp[k].pop_front());
                end
                if (flush) q_exp[k].delete();
                held[k] = q_exp[k].size();
            end
        end
    end

    function automatic logic [95:0] mk(input logic [31:0] pc);
        logic [31:0] insn;
        insn = $urandom;
        return {pc, pc + 32'd4, insn};
    endfunction

    // Applies inputs now and records acceptance as predicted by the model.
    task automatic drive(input bit f, input bit v, input logic [95:0] d, input bit r, output bit acc0);
        bit rdy;
        flush = f; up_valid = v; up_data = d; dn_ready = r;
        acc0 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rdy = skid_cfg[k] ? (held[k] < 2) : ((held[k] == 0) || r);
            if (rst_n && !f && v && rdy) begin
                q_exp[k].push_back(d);
                if (k == 0) acc0 = 1'b1;
            end
        end
    endtask

    task automatic cycle(input bit f, input bit v, input logic [95:0] d, input bit r, output bit acc0);
        @(posedge clk);
        #2;
        drive(f, v, d, r, acc0);
    endtask

    task automatic send(input logic [31:0] pc, input bit r);
        logic [95:0] d;
        bit acc;
        d = mk(pc);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, d, r, acc);
            if (acc) break;
        end
    endtask

    task automatic idle(input int n, input bit r);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, NOP, r, acc);
    endtask

    initial begin
        bit acc;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Streaming at full rate
        send(32'h100, 1'b1); send(32'h104, 1'b1); send(32'h108, 1'b1);
        idle(3, 1'b1);

        // Backpressure fills the skid entry, then release drains in order
        send(32'h200, 1'b0); send(32'h204, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, mk(32'h208), 1'b0, acc);
        send(32'h208, 1'b1);
        idle(4, 1'b1);

        // Flush while full with a beat on offer
        send(32'h2a0, 1'b0); send(32'h2a4, 1'b0);
        cycle(1'b1, 1'b1, mk(32'h300), 1'b0, acc);
        idle(2, 1'b0);
        idle(2, 1'b1);

        // Long stall saturates the narrow counter
        send(32'h500, 1'b0);
        idle(20, 1'b0);
        idle(3, 1'b1);

        // Asynchronous reset mid-cycle while full, then first beat right after release
        send(32'h600, 1'b0); send(32'h604, 1'b0);
        @(posedge clk);
        #2 drive(1'b0, 1'b0, NOP, 1'b0, acc);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        drive(1'b0, 1'b1, mk(32'h400), 1'b1, acc);
        idle(3, 1'b1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                  mk($urandom & 32'hffff_fffc), $urandom_range(0, 3) != 0, acc);
        end
        idle(5, 1'b1);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 96, payload width in bits ({pc, pc_plus_4, instruction} for the IF/ID use).
REQ-002 Parameter NOP_PAYLOAD, default {32'h00000000, 32'h00000004, 32'h00000013}, payload driven when the stage holds no valid beat.
REQ-003 Parameter SKID_EN, default 1; 1 = two-entry skid buffer with registered up_ready_o, 0 = single entry with combinational ready.
REQ-004 Parameter CNT_W, default 16, width of the statistics counters.
REQ-005 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 Port flush_i  input  1  discard every held beat and any beat offered this cycle.
REQ-008 Port up_valid_i  input  1  upstream beat valid.
REQ-009 Port up_ready_o  output  1  stage can accept an upstream beat.
REQ-010 Port up_data_i  input  DATA_W  upstream payload.
REQ-011 Port dn_valid_o  output  1  downstream beat valid.
REQ-012 Port dn_ready_i  input  1  downstream accepts the beat (replaces the old stall input: stall = !dn_ready_i).
REQ-013 Port dn_data_o  output  DATA_W  downstream payload, registered.
REQ-014 Port occupancy_o  output  2  number of held beats, 0..2.
REQ-015 Port stall_cnt_o  output  CNT_W  cycles with dn_valid_o=1 and dn_ready_i=0.
REQ-016 Port flush_cnt_o  output  CNT_W  number of cycles with flush_i=1.

Function
REQ-017 Up transfer occurs when up_valid_i & up_ready_o are 1; down transfer when dn_valid_o & dn_ready_i are 1.
REQ-018 Latency SHALL be 1 cycle: a beat accepted at edge N appears on dn_data_o with dn_valid_o=1 after edge N when the stage was empty.
REQ-019 Beats SHALL leave in acceptance order, with no loss or duplication except by flush.
REQ-020 Storage: main register (drives dn_*) and, when SKID_EN=1, skid register; states EMPTY (occ 0), ONE (occ 1), TWO (occ 2, SKID_EN=1 only).
REQ-021 EMPTY: up transfer -> main<=up_data_i, go ONE; otherwise stay.
REQ-022 ONE: up and down transfer -> main<=up_data_i, stay ONE; down only -> EMPTY; up only -> skid<=up_data_i, go TWO; neither -> hold.
REQ-023 TWO: up_ready_o=0; down transfer -> main<=skid, go ONE; otherwise hold both entries unchanged.
REQ-024 SKID_EN=1: up_ready_o SHALL be a register output, 1 iff next state is not TWO.
REQ-025 SKID_EN=0: up_ready_o = dn_ready_i | !dn_valid_o (combinational); ONE with up only -> hold, no acceptance.
REQ-026 When dn_valid_o=0, dn_data_o SHALL equal NOP_PAYLOAD; EMPTY entry (by down transfer or flush) loads NOP_PAYLOAD into main.
REQ-027 Held payload SHALL not change while dn_valid_o=1 and dn_ready_i=0.
REQ-028 flush_i=1 has priority over all transfers: next state EMPTY, main<=NOP_PAYLOAD, skid invalid, any beat offered that cycle dropped; up_ready_o=1 the following cycle.
REQ-029 Down transfer presented while flush_i=1 counts as consumed by downstream; the stage does not re-present it.
REQ-030 stall_cnt_o increments by 1 per stalled cycle, saturates at all-ones, no wrap.
REQ-031 flush_cnt_o increments by 1 per cycle with flush_i=1, saturates at all-ones, no wrap.
REQ-032 occupancy_o SHALL equal the current state count (0, 1, 2), registered.

Reset
REQ-033 rst_n=0 SHALL immediately, independent of clk: state EMPTY, dn_valid_o=0, dn_data_o=NOP_PAYLOAD, skid invalid, occupancy_o=0, both counters 0, up_ready_o=1.
REQ-034 Reset mid-operation SHALL discard all held beats; first acceptance permitted on the first rising edge after rst_n returns high.

Verification
REQ-035 Stream: dn_ready_i=1, beats pc=0x100,0x104,0x108 on consecutive cycles -> dn_data_o shows each one cycle later, occupancy_o stays 1, stall_cnt_o=0.
REQ-036 Backpressure (SKID_EN=1): dn_ready_i=0, send 0x200,0x204,0x208 -> first two held, up_ready_o=0 after second, occupancy_o=2; release -> 0x200,0x204,0x208 delivered in order, stall_cnt_o equals stalled cycles.
REQ-037 Flush in TWO: flush_i=1 one cycle with up_valid_i=1 pc=0x300 -> next cycle dn_valid_o=0, dn_data_o=NOP_PAYLOAD, occupancy_o=0, flush_cnt_o=1, 0x300 never emitted.
REQ-038 SKID_EN=0: dn_ready_i=0 with beat held -> up_ready_o=0 same cycle; dn_ready_i=1 -> up_ready_o=1 same cycle, back-to-back throughput.
REQ-039 Saturation (CNT_W=4): hold dn_ready_i=0 with a valid beat 20 cycles -> stall_cnt_o=15, no wrap.
REQ-040 Async reset asserted mid-cycle with occupancy_o=2 -> outputs reach REQ-033 values before next clk edge; after release, pc=0x400 accepted and delivered with 1-cycle latency.
